// File: rtl/csr_rmw_unit.sv
// CSR read-modify-write sequencer: executes CSRRW/CSRRS/CSRRC one at a time with a
// fixed IDLE -> READ -> WRITE -> RSP walk, returning the old CSR value to commit.
module csr_rmw_unit #(
  parameter int NW_BITS       = 2,
  parameter int UUID_BITS     = 44,
  parameter int NR_BITS       = 5,
  parameter int CSR_ADDR_BITS = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [CSR_ADDR_BITS-1:0] req_addr,
  input  logic [NW_BITS-1:0]       req_wid,
  input  logic [UUID_BITS-1:0]     req_uuid,
  input  logic [NR_BITS-1:0]       req_rd,
  input  logic [31:0]              req_src,
  input  logic                     req_src_zero,

  output logic                     read_enable,
  output logic [CSR_ADDR_BITS-1:0] read_addr,
  output logic [NW_BITS-1:0]       read_wid,
  output logic [UUID_BITS-1:0]     read_uuid,
  input  logic [31:0]              read_data,

  output logic                     write_enable,
  output logic [CSR_ADDR_BITS-1:0] write_addr,
  output logic [NW_BITS-1:0]       write_wid,
  output logic [UUID_BITS-1:0]     write_uuid,
  output logic [31:0]              write_data,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NW_BITS-1:0]       rsp_wid,
  output logic [UUID_BITS-1:0]     rsp_uuid,
  output logic [NR_BITS-1:0]       rsp_rd,
  output logic [31:0]              rsp_data,
  output logic                     rsp_illegal,

  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RSP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } op_t;

  typedef struct packed {
    op_t                     op;
    logic [CSR_ADDR_BITS-1:0] addr;
    logic [NW_BITS-1:0]       wid;
    logic [UUID_BITS-1:0]     uuid;
    logic [NR_BITS-1:0]       rd;
    logic [31:0]              src;
    logic                     src_zero;
  } req_t;

  state_t      state, state_next;
  req_t        req_q;
  logic [31:0] old_r, new_r;
  logic        wr_r, illegal_r;
  logic        accept;

  logic [31:0] new_calc;
  logic        wants_write, read_only, illegal_calc;

  // Gated by reset_n so the unit never advertises readiness while held in reset.
  assign req_ready = reset_n & ((state == S_IDLE) | ((state == S_RSP) & rsp_ready));
  assign accept    = req_valid & req_ready;

  // NOTE: state and data registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case, otherwise an
  // unassigned path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept) state_next = S_READ;
      S_READ:  state_next = S_WRITE;
      S_WRITE: state_next = S_RSP;
      S_RSP:   if (rsp_ready) state_next = req_valid ? S_READ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the request latch and result registers are ordinary flops (not a memory
  // array), so clearing them on reset is cheap and keeps every output at 0 in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.op       <= op_t'(req_op);
      req_q.addr     <= req_addr;
      req_q.wid      <= req_wid;
      req_q.uuid     <= req_uuid;
      req_q.rd       <= req_rd;
      req_q.src      <= req_src;
      req_q.src_zero <= req_src_zero;
    end
  end

  always_comb begin
    new_calc     = read_data;
    read_only    = (req_q.addr[CSR_ADDR_BITS-1 -: 2] == 2'b11);
    wants_write  = (req_q.op == OP_RW) | ~req_q.src_zero;
    // Read-only space is only illegal when the op actually intends to write it.
    illegal_calc = (req_q.op == OP_ILL) | (read_only & wants_write);
    unique case (req_q.op)
      OP_RW:   new_calc = req_q.src;
      OP_RS:   new_calc = read_data | req_q.src;
      OP_RC:   new_calc = read_data & ~req_q.src;
      default: new_calc = read_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      old_r     <= '0;
      new_r     <= '0;
      wr_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else if (state == S_READ) begin
      old_r     <= read_data;
      new_r     <= new_calc;
      wr_r      <= wants_write & ~illegal_calc;
      illegal_r <= illegal_calc;
    end
  end

  // Strobes are pure state decodes, so an asynchronous reset kills them at once.
  assign read_enable  = (state == S_READ);
  assign write_enable = (state == S_WRITE) & wr_r;
  assign rsp_valid    = (state == S_RSP);
  assign busy         = (state != S_IDLE);

  assign read_addr   = req_q.addr;
  assign read_wid    = req_q.wid;
  assign read_uuid   = req_q.uuid;

  assign write_addr  = req_q.addr;
  assign write_wid   = req_q.wid;
  assign write_uuid  = req_q.uuid;
  assign write_data  = new_r;

  assign rsp_wid     = req_q.wid;
  assign rsp_uuid    = req_q.uuid;
  assign rsp_rd      = req_q.rd;
  assign rsp_data    = old_r;
  assign rsp_illegal = illegal_r;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Directed bench for csr_rmw_unit: a behavioural CSR store answers reads combinationally
// and commits writes on the clock edge; every step compares outputs to hand values.
module tb_csr_rmw_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [1:0]  req_wid;
  logic [43:0] req_uuid;
  logic [4:0]  req_rd;
  logic [31:0] req_src;
  logic        req_src_zero;
  logic        read_enable;
  logic [11:0] read_addr;
  logic [1:0]  read_wid;
  logic [43:0] read_uuid;
  logic [31:0] read_data;
  logic        write_enable;
  logic [11:0] write_addr;
  logic [1:0]  write_wid;
  logic [43:0] write_uuid;
  logic [31:0] write_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_wid;
  logic [43:0] rsp_uuid;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        busy;

  logic [31:0] store [4096];
  int          rd_cnt;
  int          wr_cnt;
  int          checks;
  int          failures;

  csr_rmw_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wid      (req_wid),
    .req_uuid     (req_uuid),
    .req_rd       (req_rd),
    .req_src      (req_src),
    .req_src_zero (req_src_zero),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_wid     (read_wid),
    .read_uuid    (read_uuid),
    .read_data    (read_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_wid    (write_wid),
    .write_uuid   (write_uuid),
    .write_data   (write_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_wid      (rsp_wid),
    .rsp_uuid     (rsp_uuid),
    .rsp_rd       (rsp_rd),
    .rsp_data     (rsp_data),
    .rsp_illegal  (rsp_illegal),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data = store[read_addr];

  // CSR store: preload, then commit writes and count strobes at each rising edge.
  initial begin
    for (int i = 0; i < 4096; i++) store[i] = 32'h0;
    store[12'h340] = 32'h0000_1234;
    store[12'h300] = 32'h0000_00F0;
    store[12'h301] = 32'h0000_00F0;
    store[12'hC00] = 32'h5555_0000;
    store[12'h305] = 32'h0000_0011;
    store[12'h306] = 32'h0000_0066;
    store[12'h307] = 32'h0000_0001;
    rd_cnt = 0;
    wr_cnt = 0;
    forever begin
      @(posedge clk);
      if (read_enable) rd_cnt++;
      if (write_enable) begin
        wr_cnt++;
        store[write_addr] <= write_data;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic sz);
    req_valid    = 1'b1;
    req_op       = op;
    req_addr     = addr;
    req_wid      = addr[1:0];
    req_uuid     = {addr, src};
    req_rd       = src[4:0];
    req_src      = src;
    req_src_zero = sz;
  endtask

  // One full transaction from IDLE with rsp_ready held high; checks every stage.
  task automatic do_op(input string name, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] src, input logic sz, input logic [31:0] exp_old,
                       input logic exp_wr, input logic [31:0] exp_new, input logic exp_ill);
    @(negedge clk);
    check({name, " idle_ready"}, req_ready, 1);
    rsp_ready = 1'b1;
    drive_req(op, addr, src, sz);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, " read_en"}, read_enable, 1);
    check({name, " read_addr"}, read_addr, addr);
    check({name, " read_uuid"}, read_uuid, {addr, src});
    check({name, " read_wr_quiet"}, write_enable, 0);
    @(negedge clk);
    check({name, " write_en"}, write_enable, exp_wr);
    check({name, " write_rd_quiet"}, read_enable, 0);
    if (exp_wr) begin
      check({name, " write_data"}, write_data, exp_new);
      check({name, " write_addr"}, write_addr, addr);
      check({name, " write_wid"}, write_wid, addr[1:0]);
    end
    @(negedge clk);
    check({name, " rsp_valid"}, rsp_valid, 1);
    check({name, " rsp_data"}, rsp_data, exp_old);
    check({name, " rsp_illegal"}, rsp_illegal, exp_ill);
    check({name, " rsp_rd"}, rsp_rd, src[4:0]);
    check({name, " rsp_uuid"}, rsp_uuid, {addr, src});
    check({name, " rsp_req_ready"}, req_ready, 1);
    @(negedge clk);
    check({name, " back_idle"}, busy, 0);
    check({name, " rsp_drop"}, rsp_valid, 0);
  endtask

  int rd_snap;
  int wr_snap;

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_op       = 2'b00;
    req_addr     = '0;
    req_wid      = '0;
    req_uuid     = '0;
    req_rd       = '0;
    req_src      = '0;
    req_src_zero = 1'b0;
    rsp_ready    = 1'b1;

    repeat (2) @(negedge clk);
    check("rst req_ready", req_ready, 0);
    check("rst busy", busy, 0);
    check("rst read_en", read_enable, 0);
    check("rst write_en", write_enable, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_data", rsp_data, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst req_ready", req_ready, 1);

    do_op("rw",     2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_op("rs",     2'b10, 12'h300, 32'h0000_000F, 1'b0, 32'h0000_00F0, 1'b1, 32'h0000_00FF, 1'b0);
    do_op("rc",     2'b11, 12'h301, 32'h0000_00F0, 1'b0, 32'h0000_00F0, 1'b1, 32'h0000_0000, 1'b0);
    do_op("rs_zero",2'b10, 12'h300, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 32'h0000_0000, 1'b0);
    do_op("ro_rw",  2'b01, 12'hC00, 32'h0000_0001, 1'b0, 32'h5555_0000, 1'b0, 32'h0000_0000, 1'b1);
    do_op("op00",   2'b00, 12'h340, 32'h0000_0002, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b1);
    check("store rw", store[12'h340], 32'hDEAD_BEEF);
    check("store rc", store[12'h301], 32'h0000_0000);
    check("store ro kept", store[12'hC00], 32'h5555_0000);

    // Back-to-back RW to one CSR; second read must see the first write.
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(2'b01, 12'h305, 32'h0000_00AA, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b w1 data", write_data, 32'h0000_00AA);
    @(negedge clk);
    check("b2b rsp1 valid", rsp_valid, 1);
    check("b2b rsp1 data", rsp_data, 32'h0000_0011);
    drive_req(2'b01, 12'h305, 32'h0000_00BB, 1'b0);
    check("b2b ready in rsp", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b read2 en", read_enable, 1);
    check("b2b read2 data", read_data, 32'h0000_00AA);
    @(negedge clk);
    check("b2b w2 en", write_enable, 1);
    check("b2b w2 data", write_data, 32'h0000_00BB);
    @(negedge clk);
    check("b2b rsp2 data", rsp_data, 32'h0000_00AA);
    @(negedge clk);
    check("b2b idle", busy, 0);

    // Backpressure: hold rsp_ready low for five cycles with a request waiting.
    rsp_ready = 1'b0;
    drive_req(2'b01, 12'h306, 32'h0000_0077, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rd_snap = rd_cnt;
    wr_snap = wr_cnt;
    drive_req(2'b01, 12'h340, 32'h0000_0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_data", rsp_data, 32'h0000_0066);
      check("bp rsp_uuid", rsp_uuid, {12'h306, 32'h0000_0077});
      check("bp req_ready", req_ready, 0);
      check("bp read_en", read_enable, 0);
      check("bp write_en", write_enable, 0);
      @(negedge clk);
    end
    check("bp rd_cnt", rd_cnt, rd_snap);
    check("bp wr_cnt", wr_cnt, wr_snap);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp released", rsp_valid, 0);
    check("bp store", store[12'h306], 32'h0000_0077);

    // Reset asserted in the middle of WRITE.
    drive_req(2'b01, 12'h307, 32'h0000_0099, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid write_en", write_enable, 1);
    wr_snap = wr_cnt;
    #1 reset_n = 1'b0;
    #1;
    check("mid rst write_en", write_enable, 0);
    check("mid rst busy", busy, 0);
    check("mid rst req_ready", req_ready, 0);
    check("mid rst write_data", write_data, 0);
    @(negedge clk);
    check("mid rst no write", wr_cnt, wr_snap);
    check("mid rst store", store[12'h307], 32'h0000_0001);
    reset_n = 1'b1;
    @(negedge clk);
    check("after rst req_ready", req_ready, 1);
    check("after rst rsp_valid", rsp_valid, 0);
    check("after rst busy", busy, 0);
    check("after rst read_en", read_enable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
